// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: frame-rate game FSM with bird physics, pipe scrolling, collision and scoring.
// Define FLAPPY_LFSR_GAP_EN to randomise the gap centre from an 8-bit LFSR on every pipe wrap.
module flappy_game_ctrl #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned BIRD_X     = 160,
    parameter int unsigned BIRD_R     = 10,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned FLAP_V     = 8,
    parameter int unsigned VMAX       = 10,
    parameter int unsigned PIPE_W     = 40,
    parameter int unsigned GAP_HALF   = 60,
    parameter int unsigned PIPE_SPEED = 2,
    parameter int unsigned GAP_Y_DEF  = 240
) (
    input  logic       ClkPort,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flap,
    output logic [9:0] BirdXdraw,
    output logic [9:0] BirdYdraw,
    output logic [9:0] X_Edge,
    output logic [9:0] GapYdraw,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic       game_over
);
    localparam int unsigned POS_W  = 10;
    localparam int unsigned VEL_W  = 8;
    localparam int unsigned VSUM_W = VEL_W + 1;
    localparam int unsigned ARI_W  = POS_W + 1;
    localparam int unsigned CMP_W  = POS_W + 2;
    localparam int unsigned SCR_W  = 8;
    localparam int unsigned GAP_RAND_BASE = 112;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } gameStateT;

    localparam logic [POS_W-1:0] Y_START = POS_W'(SCREEN_H / 2);
    localparam logic [POS_W-1:0] Y_MAX   = POS_W'(SCREEN_H - 1);
    localparam logic [POS_W-1:0] Y_LAND  = POS_W'(SCREEN_H - 1 - BIRD_R);
    localparam logic [POS_W-1:0] X_START = POS_W'(SCREEN_W);
    localparam logic [POS_W-1:0] X_STEP  = POS_W'(PIPE_SPEED);
    localparam logic [SCR_W-1:0] SCORE_SAT = '1;

    localparam logic signed [VEL_W-1:0]  VEL_FLAP = VEL_W'(-int'(FLAP_V));
    localparam logic signed [VSUM_W-1:0] VEL_GRAV = VSUM_W'(GRAVITY);
    localparam logic signed [VSUM_W-1:0] VEL_LIM  = VSUM_W'(VMAX);

    localparam logic signed [ARI_W-1:0] ARI_ZERO = '0;
    localparam logic signed [ARI_W-1:0] Y_MAX_S  = ARI_W'(SCREEN_H - 1);
    localparam logic signed [ARI_W-1:0] R_A      = ARI_W'(BIRD_R);
    localparam logic [ARI_W-1:0]        PW_A     = ARI_W'(PIPE_W);
    localparam logic [ARI_W-1:0]        BX_A     = ARI_W'(BIRD_X);

    localparam logic signed [CMP_W-1:0] CMP_ZERO = '0;
    localparam logic signed [CMP_W-1:0] R_S      = CMP_W'(BIRD_R);
    localparam logic signed [CMP_W-1:0] HM1_S    = CMP_W'(SCREEN_H - 1);
    localparam logic signed [CMP_W-1:0] BX_S     = CMP_W'(BIRD_X);
    localparam logic signed [CMP_W-1:0] PW_S     = CMP_W'(PIPE_W);
    localparam logic signed [CMP_W-1:0] GH_S     = CMP_W'(GAP_HALF);

    gameStateT curState, nextState;

    logic [POS_W-1:0]        birdX, birdY, nextY, pipeX, nextX, gapY, nextGap;
    logic signed [VEL_W-1:0] birdVel, nextVel;
    logic [SCR_W-1:0]        scoreQ, nextScore;
    logic                    flapQ, flapPend, nextPend, gameOverQ;
    logic                    flapEdge, flapNow;
    logic [POS_W-1:0]        gapLoad;

    logic signed [VEL_W-1:0] playVel, dyVel;
    logic [POS_W-1:0]        playY, playX, playGap, dyY;
    logic [SCR_W-1:0]        playScore;
    logic                    playHit, pipeWrap, scored, dyLand;
    logic                    floorHit, overlapX, outGap;
    logic signed [ARI_W-1:0] playTry, dyTry;
    logic [ARI_W-1:0]        oldEdge, newEdge;
    logic signed [CMP_W-1:0] yS, xS, gS;

    // Gravity step with terminal velocity.
    function automatic logic signed [VEL_W-1:0] fallVel(input logic signed [VEL_W-1:0] v);
        logic signed [VSUM_W-1:0] s;
        s = VSUM_W'(v) + VEL_GRAV;
        return (s > VEL_LIM) ? VEL_W'(VEL_LIM) : VEL_W'(s);
    endfunction

    function automatic logic signed [ARI_W-1:0] yStep(input logic [POS_W-1:0] y,
                                                      input logic signed [VEL_W-1:0] v);
        return $signed({1'b0, y}) + ARI_W'(v);
    endfunction

    function automatic logic [POS_W-1:0] clampY(input logic signed [ARI_W-1:0] t);
        if (t < ARI_ZERO) return '0;
        if (t > Y_MAX_S) return Y_MAX;
        return POS_W'(t);
    endfunction

    assign flapEdge = flap & ~flapQ;
    assign flapNow  = flapPend | flapEdge;

`ifdef FLAPPY_LFSR_GAP_EN
    logic [7:0] lfsrQ;

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running on frame ticks.
    always_ff @(posedge ClkPort or negedge reset) begin
        if (!reset) begin
            lfsrQ <= 8'hA5;
        end else if (frame_tick) begin
            lfsrQ <= {lfsrQ[6:0], lfsrQ[7] ^ lfsrQ[5] ^ lfsrQ[4] ^ lfsrQ[3]};
        end
    end

    assign gapLoad = POS_W'(GAP_RAND_BASE) + POS_W'(lfsrQ);
`else
    assign gapLoad = POS_W'(GAP_Y_DEF);
`endif

    // One PLAY frame step plus collision test on the updated values.
    always_comb begin
        playVel   = flapNow ? VEL_FLAP : fallVel(birdVel);
        playTry   = yStep(birdY, playVel);
        playY     = clampY(playTry);
        pipeWrap  = (pipeX <= X_STEP);
        playX     = pipeWrap ? X_START : pipeX - X_STEP;
        playGap   = pipeWrap ? gapLoad : gapY;
        oldEdge   = {1'b0, pipeX} + PW_A;
        newEdge   = {1'b0, playX} + PW_A;
        scored    = (oldEdge >= BX_A) && (newEdge < BX_A);
        playScore = (scored && (scoreQ != SCORE_SAT)) ? scoreQ + SCR_W'(1) : scoreQ;
        yS        = $signed({2'b00, playY});
        xS        = $signed({2'b00, playX});
        gS        = $signed({2'b00, playGap});
        floorHit  = ((yS - R_S) <= CMP_ZERO) || ((yS + R_S) >= HM1_S);
        overlapX  = (xS < (BX_S + R_S)) && ((xS + PW_S) > (BX_S - R_S));
        outGap    = ((yS - R_S) < (gS - GH_S)) || ((yS + R_S) > (gS + GH_S));
        playHit   = floorHit || (overlapX && outGap);
    end

    // DYING fall: pipe frozen, bird drops until it lands on the floor line.
    always_comb begin
        dyVel  = fallVel(birdVel);
        dyTry  = yStep(birdY, dyVel);
        dyLand = (dyTry + R_A) >= Y_MAX_S;
        dyY    = dyLand ? Y_LAND : clampY(dyTry);
    end

    always_comb begin
        nextState = curState;
        nextY     = birdY;
        nextVel   = birdVel;
        nextX     = pipeX;
        nextGap   = gapY;
        nextScore = scoreQ;
        nextPend  = flapNow;
        case (curState)
            IDLE: begin
                if (frame_tick) begin
                    nextPend = 1'b0;
                    if (flapNow) begin
                        nextVel   = playVel;
                        nextY     = playY;
                        nextX     = playX;
                        nextGap   = playGap;
                        nextScore = playScore;
                        nextState = playHit ? DYING : PLAY;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    nextPend  = 1'b0;
                    nextVel   = playVel;
                    nextY     = playY;
                    nextX     = playX;
                    nextGap   = playGap;
                    nextScore = playScore;
                    if (playHit) nextState = DYING;
                end
            end
            DYING: begin
                nextPend = 1'b0;
                if (frame_tick) begin
                    nextVel = dyVel;
                    nextY   = dyY;
                    if (dyLand) nextState = OVER;
                end
            end
            OVER: begin
                if (frame_tick) begin
                    nextPend = 1'b0;
                    if (flapNow) begin
                        nextState = IDLE;
                        nextY     = Y_START;
                        nextVel   = '0;
                        nextX     = X_START;
                        nextScore = '0;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge ClkPort or negedge reset) begin
        if (!reset) begin
            curState  <= IDLE;
            birdX     <= POS_W'(BIRD_X);
            birdY     <= Y_START;
            birdVel   <= '0;
            pipeX     <= X_START;
            gapY      <= POS_W'(GAP_Y_DEF);
            scoreQ    <= '0;
            flapQ     <= 1'b0;
            flapPend  <= 1'b0;
            gameOverQ <= 1'b0;
        end else begin
            curState  <= nextState;
            birdY     <= nextY;
            birdVel   <= nextVel;
            pipeX     <= nextX;
            gapY      <= nextGap;
            scoreQ    <= nextScore;
            flapQ     <= flap;
            flapPend  <= nextPend;
            gameOverQ <= (nextState == OVER);
        end
    end

    assign BirdXdraw = birdX;
    assign BirdYdraw = birdY;
    assign X_Edge    = pipeX;
    assign GapYdraw  = gapY;
    assign score     = scoreQ;
    assign state     = curState;
    assign game_over = gameOverQ;

endmodule
